// File: rtl/pc_sequencer.sv
// pc_sequencer: hazard/redirect controller for the program counter of the
// 5-stage pipelined MIPS CPU. Picks the next PC and the PC write enable, and
// drives the IF/ID write plus the IF/ID, ID/EX and EX/MEM flush controls.
// It sequences load-use bubbles, branch/jump redirects and instruction-memory
// wait stalls, and keeps saturating stall/flush performance counters.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   pc_cur_i                current PC from the program counter
//   load_use_i              load-use hazard detected in ID
//   jump_i, jump_target_i   J/JAL in ID and its target
//   branch_taken_i,
//   branch_target_i         branch resolved taken in MEM and its target
//   imem_ready_i            instruction memory delivers a fetch this cycle
//   pc_write_o, pc_next_o   PC write enable and next PC (combinational)
//   ifid_write_o            IF/ID load enable (combinational)
//   ifid_flush_o,
//   idex_flush_o,
//   exmem_flush_o           pipeline register clears (combinational)
//   state_o                 0 RUN, 1 LD_BUBBLE, 2 IMEM_WAIT
//   timeout_o               sticky: an imem wait lasted TIMEOUT cycles
//   stall_cnt_o             cycles with pc_write_o=0, saturating
//   flush_cnt_o             redirects taken, saturating
module pc_sequencer #(
    parameter int unsigned           PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int unsigned           TIMEOUT   = 15,
    parameter int unsigned           CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [PC_WIDTH-1:0]  pc_cur_i,
    input  logic                 load_use_i,
    input  logic                 jump_i,
    input  logic [PC_WIDTH-1:0]  jump_target_i,
    input  logic                 branch_taken_i,
    input  logic [PC_WIDTH-1:0]  branch_target_i,
    input  logic                 imem_ready_i,
    output logic                 pc_write_o,
    output logic [PC_WIDTH-1:0]  pc_next_o,
    output logic                 ifid_write_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 exmem_flush_o,
    output logic [1:0]           state_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    // Wait counter only needs to reach the largest legal TIMEOUT (255).
    localparam int unsigned WAIT_WIDTH = 8;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_BUBBLE = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [WAIT_WIDTH-1:0] wait_cnt, wait_nxt;
    logic                  redirect;

    assign state_o = state;

    // Per-cycle action in priority order: branch, jump, wait hold, load-use, miss, advance.
    always_comb begin
        pc_write_o    = 1'b1;
        pc_next_o     = pc_cur_i + PC_WIDTH'(4);
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        state_nxt     = RUN;
        wait_nxt      = '0;
        redirect      = 1'b0;

        if (branch_taken_i) begin
            // Branch beats a simultaneous jump; the jump in ID is flushed with it.
            pc_next_o     = branch_target_i;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            redirect      = 1'b1;
        end else if (jump_i) begin
            pc_next_o    = jump_target_i;
            ifid_flush_o = 1'b1;
            redirect     = 1'b1;
        end else if (state == IMEM_WAIT) begin
            // load_use_i is deliberately ignored until we are back in RUN.
            if (!imem_ready_i) begin
                pc_write_o   = 1'b0;
                ifid_flush_o = 1'b1;
                state_nxt    = IMEM_WAIT;
                wait_nxt     = (wait_cnt == '1) ? wait_cnt : wait_cnt + WAIT_WIDTH'(1);
            end
        end else if (state == RUN && load_use_i) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
            state_nxt    = LD_BUBBLE;
        end else if (!imem_ready_i) begin
            pc_write_o   = 1'b0;
            ifid_flush_o = 1'b1;
            state_nxt    = IMEM_WAIT;
            wait_nxt     = WAIT_WIDTH'(1);
        end

        // Reset overrides everything so the pipeline is held and cleared.
        if (rst_i) begin
            pc_write_o    = 1'b0;
            pc_next_o     = RESET_PC;
            ifid_write_o  = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
            redirect      = 1'b0;
        end
    end

    // State, wait counter, sticky timeout and performance counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (wait_nxt >= WAIT_WIDTH'(TIMEOUT)) begin
                timeout_o <= 1'b1;
            end
            if (!pc_write_o && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + CNT_WIDTH'(1);
            end
            if (redirect && flush_cnt_o != '1) begin
                flush_cnt_o <= flush_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

endmodule
